// File: rtl/level1_pkg.sv
// level1_pkg
//   Shared types and constants for the level-1 input conditioner.
//   - db_state_t    : debouncer FSM state (STABLE, PENDING)
//   - BIT_COUNT_W   : width of the optional shifted-bit counter
//   - PASSWORD_BITS : saturation limit of that counter (password length)
package level1_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  localparam int BIT_COUNT_W   = 7;
  localparam int PASSWORD_BITS = 64;

endpackage

// File: rtl/level1_debounce.sv
// level1_debounce
//   Two-flop synchroniser followed by a STABLE/PENDING debounce FSM for one
//   raw, asynchronous board input. A new synchronised level must persist for
//   DEBOUNCE_CYCLES+1 consecutive samples (PENDING entry plus DEBOUNCE_CYCLES
//   further matches) before it is accepted into lvl.
// Ports
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   raw      : raw input, asynchronous to clk
//   lvl      : accepted (debounced) level, registered
//   lvl_next : value lvl takes at the coming edge; lets a consumer capture a
//              newly accepted level on the very edge it is accepted
//   state    : debug view of the FSM state
module level1_debounce
  import level1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw,
  output logic      lvl,
  output logic      lvl_next,
  output db_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  db_state_t     state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Synchroniser: sync2 is the first flop whose value is safe to use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      lvl   <= lvl_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lvl_next   = lvl;
    case (state)
      STABLE: begin
        if (sync2 != lvl) begin
          state_next = PENDING;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      PENDING: begin
        if (sync2 == lvl) begin
          // Bounce: the input went back before the hold time expired.
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          // Held long enough; clearing cnt here is what keeps it from wrapping.
          lvl_next   = sync2;
          state_next = STABLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/level1_input_cond.sv
// level1_input_cond
//   Input conditioner in front of the level-1 password shift register.
//   Debounces the shift button and data switch, and produces a glitch-free
//   shift level, a one-cycle shift strobe and a data bit that is frozen
//   while shift is high, so it is stable around every shift rising edge.
// Optional feature (macro LEVEL1_INPUT_COND_BIT_COUNTER_EN):
//   adds bit_count, a saturating count of accepted shift rises.
// Ports
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   shift_raw : raw shift button (asynchronous)
//   d_raw     : raw data switch (asynchronous)
//   shift_out : debounced shift level, registered
//   shift_stb : one-cycle pulse in the first cycle shift_out reads 1
//   d_out     : debounced data bit, held while shift is (or is becoming) high
//   bit_count : shifted-bit counter, saturates at PASSWORD_BITS (macro only)
module level1_input_cond
  import level1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_raw,
  input  logic                   d_raw,
  output logic                   shift_out,
  output logic                   shift_stb,
  output logic                   d_out
`ifdef LEVEL1_INPUT_COND_BIT_COUNTER_EN
  ,
  output logic [BIT_COUNT_W-1:0] bit_count
`endif
);

  logic      shift_lvl;
  logic      shift_lvl_next;
  db_state_t shift_state;
  logic      data_lvl;
  logic      data_lvl_next;
  db_state_t data_state;

  level1_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_shift_db (
    .clk      (clk),
    .rst      (rst),
    .raw      (shift_raw),
    .lvl      (shift_lvl),
    .lvl_next (shift_lvl_next),
    .state    (shift_state)
  );

  level1_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_data_db (
    .clk      (clk),
    .rst      (rst),
    .raw      (d_raw),
    .lvl      (data_lvl),
    .lvl_next (data_lvl_next),
    .state    (data_state)
  );

  // Debug-only and unneeded debouncer outputs, collected so they are consumed.
  logic unused_dbg;
  assign unused_dbg = ^{shift_lvl_next, shift_state, data_lvl, data_state};

  // shift_out lags the shift debouncer by one cycle; that extra cycle is what
  // gives d_out its setup time before the rising edge of shift_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_out <= 1'b0;
      shift_stb <= 1'b0;
    end else begin
      shift_out <= shift_lvl;
      shift_stb <= shift_lvl & ~shift_out;
    end
  end

  // d_out follows the data debouncer only while shift is fully low. It loads
  // data_lvl_next rather than data_lvl so that a data change accepted on the
  // same edge as a shift rise is still captured before the freeze begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= 1'b0;
    end else if (!shift_out && !shift_lvl) begin
      d_out <= data_lvl_next;
    end
  end

`ifdef LEVEL1_INPUT_COND_BIT_COUNTER_EN
  localparam logic [BIT_COUNT_W-1:0] BIT_COUNT_MAX = BIT_COUNT_W'(PASSWORD_BITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count <= '0;
    end else if (shift_stb && (bit_count != BIT_COUNT_MAX)) begin
      bit_count <= bit_count + 1'b1;
    end
  end
`endif

endmodule
